// File: rtl/addr_mode_if.sv
// Bundles the decoder request, sub-FSM handshake and datapath strobes of the
// operand-address sequencer. The controller takes the slave side; the
// decoder/datapath/sub-FSM environment takes the master side.
interface addr_mode_if;
    logic       go;
    logic [2:0] mode;
    logic       busy;
    logic       done;
    logic       err;
    logic       dir_start;
    logic       dir_active;
    logic       ext_start;
    logic       ext_active;
    logic       mem_read_pc;
    logic       pc_inc;
    logic [1:0] imm_fetch;
    logic       mem_read_ar;
    logic       ar_inc;
    logic [1:0] tmp_fetch;
    logic       ar_load_tmp;

    modport slave (
        input  go, mode, dir_active, ext_active,
        output busy, done, err, dir_start, ext_start,
               mem_read_pc, pc_inc, imm_fetch,
               mem_read_ar, ar_inc, tmp_fetch, ar_load_tmp
    );

    modport master (
        output go, mode, dir_active, ext_active,
        input  busy, done, err, dir_start, ext_start,
               mem_read_pc, pc_inc, imm_fetch,
               mem_read_ar, ar_inc, tmp_fetch, ar_load_tmp
    );
endinterface

// File: rtl/addr_mode_ctrl.sv
// Operand-address sequencer for one instruction. On go it latches the
// addressing mode and either fetches an inline immediate at PC, or launches
// the direct / extended sub-FSM and waits for it, optionally following with
// an indirect 16-bit fetch through AR. All outputs are Moore (state only),
// so an asynchronous reset silences every strobe at once.
module addr_mode_ctrl #(
    parameter int TIMEOUT = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    addr_mode_if.slave    bus
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [2:0] MODE_INH   = 3'd0;
    localparam logic [2:0] MODE_IMM8  = 3'd1;
    localparam logic [2:0] MODE_IMM16 = 3'd2;
    localparam logic [2:0] MODE_DIR   = 3'd3;
    localparam logic [2:0] MODE_EXT   = 3'd4;
    localparam logic [2:0] MODE_EXTI  = 3'd5;

    typedef enum logic [3:0] {
        S_IDLE,
        S_IMM_HI,
        S_IMM_LO,
        S_LAUNCH,
        S_WAIT,
        S_IND_HI,
        S_IND_LO,
        S_IND_LOAD,
        S_DONE
    } state_t;

    state_t           state, state_d;
    logic [2:0]       mode_q, mode_d;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_d;
    logic             err_q, err_d;
    logic             sel_active;

    // Only the sub-FSM launched for the latched mode is watched in WAIT.
    assign sel_active = (mode_q == MODE_DIR) ? bus.dir_active : bus.ext_active;

    // State and context registers.
    // NOTE: non-blocking assignments keep every register sampling the
    // pre-edge values, so ordering inside the block does not matter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            mode_q   <= '0;
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_d;
            mode_q   <= mode_d;
            wait_cnt <= wait_cnt_d;
            err_q    <= err_d;
        end
    end

    // Next-state / next-context logic.
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state;
        mode_d     = mode_q;
        wait_cnt_d = wait_cnt;
        err_d      = err_q;
        unique case (state)
            S_IDLE: begin
                if (bus.go) begin
                    mode_d = bus.mode;
                    unique case (bus.mode)
                        MODE_INH:                      state_d = S_DONE;
                        MODE_IMM8:                     state_d = S_IMM_LO;
                        MODE_IMM16:                    state_d = S_IMM_HI;
                        MODE_DIR, MODE_EXT, MODE_EXTI: state_d = S_LAUNCH;
                        default: begin
                            state_d = S_DONE;
                            err_d   = 1'b1;
                        end
                    endcase
                end
            end
            S_IMM_HI:   state_d = S_IMM_LO;
            S_IMM_LO:   state_d = S_DONE;
            S_LAUNCH: begin
                wait_cnt_d = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (!sel_active) begin
                    state_d = (mode_q == MODE_EXTI) ? S_IND_HI : S_DONE;
                end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt + 1'b1;
                end
            end
            S_IND_HI:   state_d = S_IND_LO;
            S_IND_LO:   state_d = S_IND_LOAD;
            S_IND_LOAD: state_d = S_DONE;
            S_DONE: begin
                state_d = S_IDLE;
                err_d   = 1'b0;
            end
            default:    state_d = S_IDLE;
        endcase
    end

    // Moore output decode.
    always_comb begin
        bus.busy        = (state != S_IDLE);
        bus.done        = 1'b0;
        bus.err         = 1'b0;
        bus.dir_start   = 1'b0;
        bus.ext_start   = 1'b0;
        bus.mem_read_pc = 1'b0;
        bus.pc_inc      = 1'b0;
        bus.imm_fetch   = 2'b00;
        bus.mem_read_ar = 1'b0;
        bus.ar_inc      = 1'b0;
        bus.tmp_fetch   = 2'b00;
        bus.ar_load_tmp = 1'b0;
        unique case (state)
            S_IMM_HI: begin
                bus.mem_read_pc = 1'b1;
                bus.pc_inc      = 1'b1;
                bus.imm_fetch   = 2'b10;
            end
            S_IMM_LO: begin
                bus.mem_read_pc = 1'b1;
                bus.pc_inc      = 1'b1;
                bus.imm_fetch   = 2'b01;
            end
            S_LAUNCH: begin
                bus.dir_start = (mode_q == MODE_DIR);
                bus.ext_start = (mode_q != MODE_DIR);
            end
            S_IND_HI: begin
                bus.mem_read_ar = 1'b1;
                bus.ar_inc      = 1'b1;
                bus.tmp_fetch   = 2'b10;
            end
            S_IND_LO: begin
                bus.mem_read_ar = 1'b1;
                bus.tmp_fetch   = 2'b01;
            end
            S_IND_LOAD: bus.ar_load_tmp = 1'b1;
            S_DONE: begin
                bus.done = 1'b1;
                bus.err  = err_q;
            end
            default: ;
        endcase
    end

endmodule
